// File: rtl/fb_pkg.sv
// Shared constants and reader state encoding for the ping-pong packed frame buffer.
package fb_pkg;

    localparam int FB_DEPTH = 5100;
    localparam int FB_AW    = $clog2(FB_DEPTH);
    localparam int FB_DW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } rd_state_t;

endpackage

// File: rtl/fb_read_streamer.sv
// Reader FSM: walks the read bank one byte at a time and hands each byte to the
// UART TX path over valid/ready.
module fb_read_streamer
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = FB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rbank,
    input  logic [DW-1:0] mem_rdata,
    input  logic          tx_ready,
    output logic          mem_re,
    output logic [AW:0]   mem_raddr,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    output logic          busy,
    output logic          frame_sent
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    rd_state_t     state;
    rd_state_t     state_next;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    state_next = PRESENT;
            PRESENT: if (tx_ready) state_next = (rd_addr == LAST_ADDR) ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx_data is captured in WAIT so it stays stable for the whole PRESENT stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            tx_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                rd_addr <= '0;
            end else if (state == PRESENT && tx_ready && rd_addr != LAST_ADDR) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (state == WAIT) begin
                tx_data <= mem_rdata;
            end
        end
    end

    always_comb begin
        mem_re     = 1'b0;
        mem_raddr  = '0;
        tx_valid   = 1'b0;
        frame_sent = 1'b0;
        busy       = (state != IDLE);
        case (state)
            FETCH: begin
                mem_re    = 1'b1;
                mem_raddr = {rbank, rd_addr};
            end
            PRESENT: tx_valid   = 1'b1;
            DONE:    frame_sent = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/frame_buf_pingpong_ctrl.sv
// Ping-pong controller: steers packer writes into the write bank, swaps banks on
// frame completion while the reader is idle, and streams the read bank on request.
module frame_buf_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = FB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_frame_tick,
    input  logic          start_req,
    output logic          mem_we,
    output logic [AW:0]   mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic [AW:0]   mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          frame_sent,
    output logic          frame_dropped
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic wbank;
    logic frame_valid;
    logic req_pend;
    logic reader_busy;
    logic serve;

    // A start_req pulse is served in its own cycle when a frame is already waiting.
    assign serve = !reader_busy && frame_valid && (req_pend || start_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            wbank         <= 1'b0;
            frame_valid   <= 1'b0;
            req_pend      <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= wr_frame_tick && reader_busy;
            if (wr_frame_tick && !reader_busy) begin
                wbank       <= ~wbank;
                frame_valid <= 1'b1;
            end else if (frame_sent) begin
                frame_valid <= 1'b0;
            end
            if (serve) begin
                req_pend <= 1'b0;
            end else if (start_req) begin
                req_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_we    = !reset && wr_we && ({1'b0, wr_addr} < DEPTH_W);
        mem_waddr = {wbank, wr_addr};
        mem_wdata = wr_data;
    end

    assign busy = reader_busy;

    fb_read_streamer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_reader (
        .clk        (clk),
        .reset      (reset),
        .start      (serve),
        .rbank      (~wbank),
        .mem_rdata  (mem_rdata),
        .tx_ready   (tx_ready),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (reader_busy),
        .frame_sent (frame_sent)
    );

endmodule

// File: tb/tb_frame_buf_pingpong_ctrl.sv
// Scoreboard bench for frame_buf_pingpong_ctrl with a behavioural dual-bank BRAM.
module tb_frame_buf_pingpong_ctrl;

    localparam int DEPTH = 5100;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_frame_tick;
    logic          start_req;
    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [AW:0]   mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          frame_sent;
    logic          frame_dropped;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] bram [0:(1 << (AW + 1)) - 1];

    bit         mon_prev_stall = 1'b0;
    logic [7:0] mon_prev_data  = '0;

    always #5 clk = ~clk;

    frame_buf_pingpong_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_we         (wr_we),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_frame_tick (wr_frame_tick),
        .start_req     (start_req),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .mem_re        (mem_re),
        .mem_raddr     (mem_raddr),
        .mem_rdata     (mem_rdata),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .frame_sent    (frame_sent),
        .frame_dropped (frame_dropped)
    );

    // Synchronous-read BRAM: data appears one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) bram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= bram[mem_raddr];
    end

    // Scoreboard: every accepted byte pops the next expected byte; stalls must hold data.
    always @(negedge clk) begin
        if (reset) begin
            mon_prev_stall = 1'b0;
        end else begin
            if (mon_prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== mon_prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required tx_valid=1 tx_data=%h",
                             tx_valid, tx_data, mon_prev_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_byte: got %h, required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL sb_data: got %h, required %h (%0d left)", tx_data, e, exp_q.size());
                    end
                end
            end
            mon_prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            mon_prev_data  = tx_data;
        end
    end

    function automatic logic [7:0] pat(input int sel, input int a);
        logic [31:0] v;
        case (sel)
            0:       v = a;
            1:       v = a * 7 + 3;
            default: v = a ^ 32'hA5;
        endcase
        return v[7:0];
    endfunction

    task automatic push_frame(input int sel);
        for (int a = 0; a < DEPTH; a++) exp_q.push_back(pat(sel, a));
    endtask

    task automatic write_frame(input int sel);
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk); #1;
            wr_we   = 1'b1;
            wr_addr = AW'(a);
            wr_data = pat(sel, a);
        end
        @(posedge clk); #1;
        wr_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW:0] ew;
        reset = 1'b1; wr_we = 1'b0; wr_addr = '0; wr_data = '0;
        wr_frame_tick = 1'b0; start_req = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_sent !== 1'b0 || frame_dropped !== 1'b0 ||
            mem_re !== 1'b0 || mem_we !== 1'b0 || mem_raddr !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b sent=%b drop=%b re=%b we=%b raddr=%h data=%h, required all 0",
                     tx_valid, busy, frame_sent, frame_dropped, mem_re, mem_we, mem_raddr, tx_data);
        end
        @(posedge clk); #1;
        reset = 1'b0; wr_addr = AW'(5);
        @(negedge clk);
        ew = {1'b0, AW'(5)};
        checks++;
        if (mem_waddr !== ew) begin
            errors++;
            $display("FAIL reset_wbank: mem_waddr=%h, required %h", mem_waddr, ew);
        end
    endtask

    task automatic test_write_frame();
        int drops = 0;
        write_frame(0);
        @(posedge clk); #1; wr_frame_tick = 1'b1;
        @(posedge clk); #1; wr_frame_tick = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (frame_dropped === 1'b1) drops++;
        end
        checks++;
        if (mem_waddr[AW] !== 1'b1) begin
            errors++;
            $display("FAIL swap_wbank: wbank=%b, required 1", mem_waddr[AW]);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL swap_no_drop: frame_dropped pulses=%0d, required 0", drops);
        end
    endtask

    task automatic test_stream();
        int acc = 0, last = -1, gaps_bad = 0, sent = 0, sent_at = -1, post = 0;
        logic [AW:0] ea;
        push_frame(0);
        tx_ready = 1'b1;
        @(posedge clk); #1; start_req = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL lat_c0: tx_valid=%b, required 0", tx_valid);
        end
        @(posedge clk); #1; start_req = 1'b0;
        @(negedge clk);
        ea = '0;
        checks++;
        if (busy !== 1'b1 || mem_re !== 1'b1 || mem_raddr !== ea || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_fetch: busy=%b re=%b raddr=%h valid=%b, required 1 1 %h 0",
                     busy, mem_re, mem_raddr, tx_valid, ea);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL lat_c2: tx_valid=%b, required 0", tx_valid);
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            errors++; $display("FAIL lat_c3: tx_valid=%b data=%h, required 1 00", tx_valid, tx_data);
        end
        for (int n = 0; n < 20000; n++) begin
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                acc++;
                if (last >= 0 && n - last != 3) gaps_bad++;
                last = n;
            end
            if (frame_sent === 1'b1) begin
                sent++;
                sent_at = n;
            end
            if (sent > 0) begin
                post++;
                if (post > 5) break;
            end
            @(negedge clk);
        end
        checks++;
        if (acc != DEPTH) begin
            errors++; $display("FAIL stream_count: accepted=%0d, required %0d", acc, DEPTH);
        end
        checks++;
        if (gaps_bad != 0) begin
            errors++; $display("FAIL stream_rate: bad gaps=%0d, required 0 (3 cycles/byte)", gaps_bad);
        end
        checks++;
        if (sent != 1 || sent_at != last + 1) begin
            errors++;
            $display("FAIL stream_sent: pulses=%0d at %0d, required 1 at %0d", sent, sent_at, last + 1);
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: left=%0d busy=%b, required 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_stall_drop();
        int acc = 0, drops = 0, drop_n = -1, tick_n = -1, bank_bad = 0, sent = 0, post = 0;
        bit fired = 1'b0;
        write_frame(1);
        @(posedge clk); #1; wr_frame_tick = 1'b1;
        @(posedge clk); #1; wr_frame_tick = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_waddr[AW] !== 1'b0) begin
            errors++; $display("FAIL swap2_wbank: wbank=%b, required 0", mem_waddr[AW]);
        end
        push_frame(1);
        @(posedge clk); #1; start_req = 1'b1; tx_ready = 1'b0;
        for (int n = 0; n < 60000; n++) begin
            @(posedge clk); #1;
            start_req     = 1'b0;
            wr_frame_tick = 1'b0;
            wr_we         = 1'b0;
            tx_ready      = ($urandom_range(0, 99) < 30);
            if (!fired && acc >= 50) begin
                wr_frame_tick = 1'b1;
                wr_we         = 1'b1;
                wr_addr       = AW'(acc);
                wr_data       = 8'hFF;
                fired         = 1'b1;
                tick_n        = n;
            end
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) acc++;
            if (frame_dropped === 1'b1) begin
                drops++;
                drop_n = n;
            end
            if (mem_waddr[AW] !== 1'b0) bank_bad++;
            if (frame_sent === 1'b1) sent++;
            if (sent > 0) begin
                post++;
                if (post > 5) break;
            end
        end
        tx_ready = 1'b0;
        checks++;
        if (drops != 1 || drop_n != tick_n + 1) begin
            errors++;
            $display("FAIL drop_pulse: pulses=%0d at %0d, required 1 at %0d", drops, drop_n, tick_n + 1);
        end
        checks++;
        if (bank_bad != 0) begin
            errors++; $display("FAIL drop_wbank: cycles with wbank!=0 = %0d, required 0", bank_bad);
        end
        checks++;
        if (acc != DEPTH || sent != 1) begin
            errors++;
            $display("FAIL stall_stream: accepted=%0d sent=%0d, required %0d 1", acc, sent, DEPTH);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stall_left: left=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_late_tick();
        int idle_bad = 0;
        logic [AW:0] ea;
        write_frame(2);
        tx_ready = 1'b1;
        @(posedge clk); #1; start_req = 1'b1;
        @(posedge clk); #1; start_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_valid !== 1'b0 || mem_re !== 1'b0) idle_bad++;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++; $display("FAIL noframe_idle: active cycles=%0d, required 0", idle_bad);
        end
        push_frame(2);
        @(posedge clk); #1; wr_frame_tick = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL late_tick_cycle: busy=%b, required 0", busy);
        end
        @(posedge clk); #1; wr_frame_tick = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_waddr[AW] !== 1'b1) begin
            errors++;
            $display("FAIL late_swap: busy=%b wbank=%b, required 0 1", busy, mem_waddr[AW]);
        end
        @(negedge clk);
        ea = '0;
        checks++;
        if (busy !== 1'b1 || mem_re !== 1'b1 || mem_raddr !== ea) begin
            errors++;
            $display("FAIL late_start: busy=%b re=%b raddr=%h, required 1 1 %h", busy, mem_re, mem_raddr, ea);
        end
    endtask

    task automatic test_reset_mid_stream();
        int acc = 0, sent = 0, after_bad = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) acc++;
            if (frame_sent === 1'b1) sent++;
            if (acc == 100) break;
        end
        checks++;
        if (acc != 100) begin
            errors++; $display("FAIL abort_reach: accepted=%0d, required 100", acc);
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
        end
        exp_q.delete();
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; start_req = 1'b1;
        @(posedge clk); #1; start_req = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (frame_sent === 1'b1) sent++;
            if (busy !== 1'b0 || tx_valid !== 1'b0) after_bad++;
        end
        checks++;
        if (sent != 0) begin
            errors++; $display("FAIL abort_sent: frame_sent pulses=%0d, required 0", sent);
        end
        checks++;
        if (after_bad != 0 || mem_waddr[AW] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: active cycles=%0d wbank=%b, required 0 0", after_bad, mem_waddr[AW]);
        end
    endtask

    task automatic test_addr_range();
        logic [AW:0] ew;
        @(posedge clk); #1;
        wr_we = 1'b1; wr_addr = AW'(DEPTH); wr_data = 8'h5A;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL addr_5100: mem_we=%b, required 0", mem_we);
        end
        @(posedge clk); #1; wr_addr = AW'(DEPTH - 1);
        @(negedge clk);
        ew = {1'b0, AW'(DEPTH - 1)};
        checks++;
        if (mem_we !== 1'b1 || mem_waddr !== ew || mem_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL addr_5099: we=%b waddr=%h wdata=%h, required 1 %h 5a", mem_we, mem_waddr, mem_wdata, ew);
        end
        @(posedge clk); #1; wr_addr = '1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL addr_max: mem_we=%b, required 0", mem_we);
        end
        @(posedge clk); #1; wr_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_stream();
        test_stall_drop();
        test_late_tick();
        test_reset_mid_stream();
        test_addr_range();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
